// File: rtl/apb_fifo_bridge.sv
// APB slave fronting a synchronous FIFO: DATA writes push, DATA reads pop, plus STATUS/CTRL/THRESH registers.
// Optional threshold interrupt (irq port, THRESH register) is enabled by defining FIFO_IRQ_EN.
module apb_fifo_bridge #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              channel_psel,
    input  logic              channel_penable,
    input  logic              channel_pwrite,
    input  logic [ADDR_W-1:0] channel_paddr,
    input  logic [DATA_W-1:0] channel_pwdata,
    output logic [DATA_W-1:0] channel_prdata,
    output logic              channel_pready
`ifdef FIFO_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_t;

    state_t state, state_next;

    logic              xfer_write;
    logic              xfer_mapped;
    reg_t              xfer_reg;
    logic [DATA_W-1:0] xfer_wdata;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  rptr, wptr, count;
    logic              ovf, udf;
    logic              empty, full, irq_flag;
    logic              addr_mapped;
    logic [DATA_W-1:0] status, rd_data;
    logic              commit, push, pop, ctrl_wr;

    assign empty = (count == CNT_W'(0));
    assign full  = (count == CNT_W'(DEPTH));

    // Low-order byte-lane bits and everything above the 16-byte window must be zero.
    always_comb begin
        addr_mapped = (channel_paddr[ADDR_W-1:4] == '0) && (channel_paddr[1:0] == 2'b00);
`ifndef FIFO_IRQ_EN
        if (channel_paddr[3:2] == REG_THRESH) addr_mapped = 1'b0;
`endif
    end

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (channel_psel && !channel_penable) state_next = ACCESS;
            ACCESS: begin
                if (!channel_psel)         state_next = IDLE;
                else if (channel_penable)  state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            channel_pready <= 1'b0;
        end else begin
            state          <= state_next;
            channel_pready <= (state_next == RESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_write  <= 1'b0;
            xfer_mapped <= 1'b0;
            xfer_reg    <= REG_DATA;
            xfer_wdata  <= '0;
        end else if (state == IDLE && channel_psel && !channel_penable) begin
            xfer_write  <= channel_pwrite;
            xfer_mapped <= addr_mapped;
            xfer_reg    <= reg_t'(channel_paddr[3:2]);
            xfer_wdata  <= channel_pwdata;
        end
    end

`ifdef FIFO_IRQ_EN
    logic [CNT_W-1:0] thresh;
    logic             thresh_wr;

    assign thresh_wr = commit && xfer_write && (xfer_reg == REG_THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh <= CNT_W'(DEPTH / 2);
            irq    <= 1'b0;
        end else begin
            if (thresh_wr) thresh <= xfer_wdata[CNT_W-1:0];
            irq <= (thresh != '0) && (count >= thresh);
        end
    end

    assign irq_flag = irq;
`else
    assign irq_flag = 1'b0;
`endif

    always_comb begin
        status           = '0;
        status[0]        = empty;
        status[1]        = full;
        status[2]        = ovf;
        status[3]        = udf;
        status[4]        = irq_flag;
        status[8 +: CNT_W] = count;
    end

    always_comb begin
        rd_data = '0;
        if (xfer_mapped) begin
            case (xfer_reg)
                REG_DATA:   if (!empty) rd_data = mem[rptr[IDX_W-1:0]];
                REG_STATUS: rd_data = status;
`ifdef FIFO_IRQ_EN
                REG_THRESH: rd_data[CNT_W-1:0] = thresh;
`endif
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            channel_prdata <= '0;
        end else if (state == ACCESS && channel_psel && channel_penable && !xfer_write) begin
            channel_prdata <= rd_data;
        end
    end

    // Side effects land on the RESP -> IDLE edge, so an aborted or reset transfer never commits.
    assign commit  = (state == RESP) && xfer_mapped;
    assign push    = commit &&  xfer_write && (xfer_reg == REG_DATA);
    assign pop     = commit && !xfer_write && (xfer_reg == REG_DATA);
    assign ctrl_wr = commit &&  xfer_write && (xfer_reg == REG_CTRL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                if (xfer_wdata[0]) begin
                    rptr  <= '0;
                    wptr  <= '0;
                    count <= '0;
                end
                if (xfer_wdata[1]) begin
                    ovf <= 1'b0;
                    udf <= 1'b0;
                end
            end else if (push) begin
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    wptr  <= wptr + CNT_W'(1);
                    count <= count + CNT_W'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    udf <= 1'b1;
                end else begin
                    rptr  <= rptr + CNT_W'(1);
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: storage array has no reset; only pointers/count define validity, and flush leaves contents alone.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[IDX_W-1:0]] <= xfer_wdata;
    end

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Self-checking bench for apb_fifo_bridge: queue-based FIFO model plus per-cycle output comparison.
// Define FIFO_IRQ_EN for both bench and RTL to exercise the threshold interrupt.
module tb_apb_fifo_bridge;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
`ifdef FIFO_IRQ_EN
    logic        irq;
`endif

    apb_fifo_bridge #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .channel_psel    (psel),
        .channel_penable (penable),
        .channel_pwrite  (pwrite),
        .channel_paddr   (paddr),
        .channel_pwdata  (pwdata),
        .channel_prdata  (prdata),
        .channel_pready  (pready)
`ifdef FIFO_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] q[$];
    bit          m_ovf = 0;
    bit          m_udf = 0;
    int          m_thresh = DEPTH / 2;
    logic        exp_pready = 1'b0;
    logic [31:0] exp_prdata = '0;
    logic        exp_irq = 1'b0;

    function automatic logic m_irq();
`ifdef FIFO_IRQ_EN
        return (m_thresh != 0) && (q.size() >= m_thresh);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_mapped(input logic [31:0] a);
        if (a[31:4] != 0 || a[1:0] != 0) return 0;
`ifndef FIFO_IRQ_EN
        if (a[3:2] == 2'd3) return 0;
`endif
        return 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] s;
        s = '0;
        if (!m_mapped(a)) return s;
        case (a[3:2])
            2'd0: if (q.size() != 0) s = q[0];
            2'd1: begin
                s[0] = (q.size() == 0);
                s[1] = (q.size() == DEPTH);
                s[2] = m_ovf;
                s[3] = m_udf;
                s[4] = m_irq();
                s[8 +: CNT_W] = CNT_W'(q.size());
            end
            2'd3: s = 32'(m_thresh);
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic m_commit(input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (!m_mapped(a)) return;
        if (!wr) begin
            if (a[3:2] == 2'd0) begin
                if (q.size() == 0) m_udf = 1;
                else void'(q.pop_front());
            end
        end else begin
            case (a[3:2])
                2'd0: if (q.size() == DEPTH) m_ovf = 1; else q.push_back(d);
                2'd2: begin
                    if (d[0]) q.delete();
                    if (d[1]) begin m_ovf = 0; m_udf = 0; end
                end
                2'd3: m_thresh = int'(d[CNT_W-1:0]);
                default: ;
            endcase
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_thresh = DEPTH / 2;
        exp_pready = 1'b0;
        exp_prdata = '0;
        exp_irq = 1'b0;
    endtask

    // Per-cycle compare: outputs sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("pready", 32'(pready), 32'(exp_pready));
            check("prdata", prdata, exp_prdata);
`ifdef FIFO_IRQ_EN
            check("irq", 32'(irq), 32'(exp_irq));
`endif
            // irq is registered: after the next edge it reflects the state as it stands now.
            exp_irq = m_irq();
        end
    end

    // ---------------- APB driver ----------------
    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        pwdata = ~d;
        exp_pready = 1'b1;
        if (!wr) exp_prdata = m_read(a);
        @(negedge clk);
        rd = prdata;
        psel = 1'b0; penable = 1'b0;
        exp_pready = 1'b0;
        m_commit(wr, a, d);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] unused;
        apb_xfer(1'b1, a, d, unused);
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] rd);
        apb_xfer(1'b0, a, 32'h0, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;

    initial begin
        // 1. reset and STATUS
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_pready", 32'(pready), 32'h0);
        check("reset_prdata", prdata, 32'h0);
        rd_reg(32'h4, rd);
        check("status_reset", rd, 32'h0000_0001);

        // 2. three pushes, three pops
        for (int i = 1; i <= 3; i++) wr_reg(32'h0, 32'hA5A5_0000 + 32'(i));
        rd_reg(32'h4, rd);
        check("status_cnt3", rd, 32'h0000_0300);
        for (int i = 1; i <= 3; i++) begin
            rd_reg(32'h0, rd);
            check("data_small", rd, 32'hA5A5_0000 + 32'(i));
        end
        rd_reg(32'h4, rd);
        check("status_cnt0", rd, 32'h0000_0001);

        // 3. overflow then underflow
        for (int i = 0; i < 17; i++) wr_reg(32'h0, 32'h1000_0000 + 32'(i));
        rd_reg(32'h4, rd);
`ifdef FIFO_IRQ_EN
        check("status_full", rd, 32'h0000_1016);
`else
        check("status_full", rd, 32'h0000_1006);
`endif
        for (int i = 0; i < 16; i++) begin
            rd_reg(32'h0, rd);
            check("data_full", rd, 32'h1000_0000 + 32'(i));
        end
        rd_reg(32'h0, rd);
        check("data_underflow", rd, 32'h0);
        rd_reg(32'h4, rd);
        check("status_ovf_udf", rd, 32'h0000_000D);

        // 4. pointer wrap, then clear everything
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) wr_reg(32'h0, 32'hC0DE_0000 + 32'(r * 16 + i));
            for (int i = 0; i < 10; i++) begin
                rd_reg(32'h0, rd);
                check("data_wrap", rd, 32'hC0DE_0000 + 32'(r * 16 + i));
            end
        end
        wr_reg(32'h8, 32'h3);
        rd_reg(32'h4, rd);
        check("status_clear", rd, 32'h0000_0001);

        // flush keeps flags; clear alone drops them
        for (int i = 0; i < 3; i++) wr_reg(32'h0, 32'h5555_0000 + 32'(i));
        wr_reg(32'h8, 32'h1);
        rd_reg(32'h4, rd);
        check("status_flush", rd, 32'h0000_0001);
        rd_reg(32'h0, rd);
        check("data_after_flush", rd, 32'h0);
        rd_reg(32'h4, rd);
        check("status_udf", rd, 32'h0000_0009);
        wr_reg(32'h8, 32'h2);
        rd_reg(32'h4, rd);
        check("status_clr_only", rd, 32'h0000_0001);

        // unmapped and write-only registers
        wr_reg(32'h10, 32'h1234_5678);
        wr_reg(32'h1, 32'h1234_5678);
        rd_reg(32'h4, rd);
        check("status_unmapped_wr", rd, 32'h0000_0001);
        rd_reg(32'h10, rd);
        check("rd_unmapped_hi", rd, 32'h0);
        wr_reg(32'h0, 32'hBEEF_0001);
        rd_reg(32'h2, rd);
        check("rd_unmapped_lo", rd, 32'h0);
        rd_reg(32'h8, rd);
        check("rd_ctrl", rd, 32'h0);
`ifndef FIFO_IRQ_EN
        rd_reg(32'hC, rd);
        check("rd_thresh_absent", rd, 32'h0);
`endif
        rd_reg(32'h0, rd);
        check("data_after_unmapped", rd, 32'hBEEF_0001);

        // 5. reset during ACCESS of a DATA write, then an aborted transfer
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hDEAD_0001;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        psel = 1'b0;
        m_reset();
        check("rst_mid_pready", 32'(pready), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_reg(32'h4, rd);
        check("status_after_rst", rd, 32'h0000_0001);

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hDEAD_0002;
        @(negedge clk);
        psel = 1'b0;
        repeat (3) @(negedge clk);
        rd_reg(32'h4, rd);
        check("status_after_abort", rd, 32'h0000_0001);

`ifdef FIFO_IRQ_EN
        // 6. threshold interrupt
        wr_reg(32'hC, 32'h4);
        rd_reg(32'hC, rd);
        check("thresh_rd", rd, 32'h4);
        for (int i = 0; i < 3; i++) wr_reg(32'h0, 32'h7700_0000 + 32'(i));
        repeat (2) @(negedge clk);
        check("irq_below", 32'(irq), 32'h0);
        wr_reg(32'h0, 32'h7700_0003);
        @(posedge clk); #2;
        check("irq_commit_cycle", 32'(irq), 32'h0);
        @(posedge clk); #2;
        check("irq_set", 32'(irq), 32'h1);
        rd_reg(32'h0, rd);
        check("irq_pop_data", rd, 32'h7700_0000);
        @(posedge clk); #2;
        check("irq_pop_commit", 32'(irq), 32'h1);
        @(posedge clk); #2;
        check("irq_clear", 32'(irq), 32'h0);
        wr_reg(32'hC, 32'h0);
        wr_reg(32'h0, 32'h7700_0004);
        repeat (3) @(negedge clk);
        check("irq_thresh0", 32'(irq), 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
